// File: rtl/neuron_mac_stage.sv
// neuron_mac_stage: multiply-accumulate stage for one neuron of a layer.
// Accumulates x_in*w_in on each ack and finalizes on the rising edge of ack_mac.
// Finalizing adds the bias, rescales, saturates and emits z with a one-cycle z_valid.
// All state updates on the falling clock edge so the stage runs in lockstep with
// the layer's input counter. The reset rst is asynchronous and active-low.
// Optional feature: define NEURON_MAC_RELU_EN to clamp negative outputs to zero
// after saturation. sat still reports the clip when that option is enabled.
//
// Handshake: ack is a strobe with no back-pressure. x_in and w_in are consumed on
// every falling edge where ack=1. z_valid is a strobe of the same kind, one cycle
// wide, with no ready. A downstream counter must take z on the edge where it sees
// z_valid=1.
module neuron_mac_stage #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int N_IN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ack,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] w_in,
    input  logic signed [W-1:0] bias,
    input  logic                ack_mac,
    output logic signed [W-1:0] z,
    output logic                z_valid,
    output logic                sat
);

    // Headroom for N_IN full-scale products plus the shifted bias.
    localparam int ACC_W = 2*W + $clog2(N_IN) + 1;

    // Output range limits, expressed at accumulator width for the compare.
    localparam logic signed [ACC_W-1:0] Z_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Z_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ack_mac_q;
    logic signed [W-1:0]     r_z;
    logic                    r_z_valid;
    logic                    r_sat;

    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_r;
    logic                    w_fin;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic signed [W-1:0]     w_z_nxt;
    logic                    w_sat_nxt;

    // Full-precision product, carrying 2*FRAC fractional bits.
    assign w_prod     = x_in * w_in;
    assign w_prod_ext = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
    // Bias is moved up to the product scale before it is added to the sum.
    assign w_bias_ext = {{(ACC_W-W){bias[W-1]}}, bias} <<< FRAC;
    assign w_sum      = r_acc + w_bias_ext;
    assign w_r        = w_sum >>> FRAC;

    // Only the rising edge of ack_mac finalizes a vector.
    assign w_fin = ack_mac & ~r_ack_mac_q;

    // Accumulator next value: seed or clear on finalize, add on ack, else hold.
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_fin) begin
            w_acc_nxt = ack ? w_prod_ext : '0;
        end else if (ack) begin
            w_acc_nxt = r_acc + w_prod_ext;
        end
    end

    // Saturate the rescaled sum to W bits, then apply the optional ReLU clamp.
    always_comb begin
        w_z_nxt   = w_r[W-1:0];
        w_sat_nxt = 1'b0;
        if (w_r > Z_MAX) begin
            w_z_nxt   = Z_MAX[W-1:0];
            w_sat_nxt = 1'b1;
        end else if (w_r < Z_MIN) begin
            w_z_nxt   = Z_MIN[W-1:0];
            w_sat_nxt = 1'b1;
        end
`ifdef NEURON_MAC_RELU_EN
        if (w_z_nxt[W-1]) begin
            w_z_nxt = '0;
        end
`else
`endif
    end

    // Falling-edge state: accumulator, ack_mac history, and the output register set.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_ack_mac_q <= 1'b0;
            r_z         <= '0;
            r_z_valid   <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_ack_mac_q <= ack_mac;
            r_z_valid   <= w_fin;
            if (w_fin) begin
                r_z   <= w_z_nxt;
                r_sat <= w_sat_nxt;
            end
        end
    end

    assign z       = r_z;
    assign z_valid = r_z_valid;
    assign sat     = r_sat;

endmodule

// File: tb/tb_neuron_mac_stage.sv
// tb_neuron_mac_stage: directed bench for neuron_mac_stage (W=16, FRAC=8, N_IN=2).
// Expected {z, sat} pairs are queued when a finalize is driven and are popped when
// z_valid appears.
module tb_neuron_mac_stage;

    localparam int W = 16;

    logic                clk;
    logic                rst;
    logic                ack;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] w_in;
    logic signed [W-1:0] bias;
    logic                ack_mac;
    logic signed [W-1:0] z;
    logic                z_valid;
    logic                sat;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int pushes   = 0;
    logic prev_valid = 1'b0;

    logic [W:0] exp_q[$];

    neuron_mac_stage #(.W(16), .FRAC(8), .N_IN(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ack     (ack),
        .x_in    (x_in),
        .w_in    (w_in),
        .bias    (bias),
        .ack_mac (ack_mac),
        .z       (z),
        .z_valid (z_valid),
        .sat     (sat)
    );

    // Clock: falling edges at 5, 15, 25, ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] ez, input logic es);
        exp_q.push_back({es, ez});
        pushes++;
    endtask

    // Advance to 1 time unit after the next falling edge, then score any output.
    task automatic tick();
        logic [W:0] e;
        @(negedge clk);
        #1;
        if (z_valid === 1'b1) begin
            pulses++;
            check("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_z_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("z", {16'd0, z}, {16'd0, e[W-1:0]});
                check("sat", {31'd0, sat}, {31'd0, e[W]});
            end
        end
        prev_valid = z_valid;
    endtask

    task automatic drive(input logic a, input logic [W-1:0] x, input logic [W-1:0] w,
                         input logic am);
        ack     = a;
        x_in    = x;
        w_in    = w;
        ack_mac = am;
        tick();
    endtask

    int p0;

    initial begin
        rst = 1'b0; ack = 1'b0; x_in = '0; w_in = '0; bias = '0; ack_mac = 1'b0;
        tick();
        tick();
        check("reset_z", {16'd0, z}, 32'd0);
        check("reset_z_valid", {31'd0, z_valid}, 32'd0);
        check("reset_sat", {31'd0, sat}, 32'd0);
        rst = 1'b1;
        tick();

        // Basic vector: 0.5 + 0.25 - 0.5 = 0.25
        drive(1'b1, 16'h0100, 16'h0080, 1'b0);
        drive(1'b1, 16'h0100, 16'h0040, 1'b0);
        bias = 16'hFF80;
        push(16'h0040, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        check("basic_z_valid", {31'd0, z_valid}, 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        check("basic_valid_one_cycle", {31'd0, z_valid}, 32'd0);
        check("basic_z_held", {16'd0, z}, 32'h0040);
        bias = 16'h0000;

        // Negative in-range result
        drive(1'b1, 16'h0100, 16'hFF00, 1'b0);
        drive(1'b1, 16'h0000, 16'h0100, 1'b0);
`ifdef NEURON_MAC_RELU_EN
        push(16'h0000, 1'b0);
`else
        push(16'hFF00, 1'b0);
`endif
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Back-to-back: A finalizes while the next vector's first element arrives
        drive(1'b1, 16'h0100, 16'h0100, 1'b0);
        push(16'h0100, 1'b0);
        drive(1'b1, 16'h0200, 16'h0100, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 16'h0100, 16'h0100, 1'b0);
        push(16'h0300, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Held ack_mac: one pulse only, and the accumulator stays cleared
        drive(1'b1, 16'h0100, 16'h0100, 1'b0);
        p0 = pulses;
        push(16'h0100, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        check("held_ack_mac_pulses", pulses - p0, 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 16'h0100, 16'h0040, 1'b0);
        push(16'h0040, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Negative saturation
        drive(1'b1, 16'h7F00, 16'h8100, 1'b0);
        drive(1'b1, 16'h7F00, 16'h8100, 1'b0);
`ifdef NEURON_MAC_RELU_EN
        push(16'h0000, 1'b1);
`else
        push(16'h8000, 1'b1);
`endif
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Positive saturation
        drive(1'b1, 16'h7F00, 16'h7F00, 1'b0);
        drive(1'b1, 16'h7F00, 16'h7F00, 1'b0);
        push(16'h7FFF, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        check("sat_held", {31'd0, sat}, 32'd1);

        // Reset mid-vector, between edges
        drive(1'b1, 16'h0100, 16'h0100, 1'b0);
        ack = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("midreset_z", {16'd0, z}, 32'd0);
        check("midreset_z_valid", {31'd0, z_valid}, 32'd0);
        check("midreset_sat", {31'd0, sat}, 32'd0);
        #2 rst = 1'b1;
        tick();
        drive(1'b1, 16'h0100, 16'h0100, 1'b0);
        drive(1'b1, 16'h0100, 16'h0080, 1'b0);
        push(16'h0180, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();

        check("queue_drained", exp_q.size(), 32'd0);
        check("pulse_count", pulses, pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
